// File: rtl/serializador.sv
// Parallel-to-serial frame transmitter, MSB first, optional even-parity bit (macro SER_PARITY_EN).
// Latency: first bit strobed one edge after accept; done_out pulses in the gap cycle after the last bit.
// Backpressure: ready_out low while the hold register is full; no frame starts while status_in is high.
module serializador #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk_100KHz,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  valid_in,
  output logic                  ready_out,
  input  logic                  status_in,
  output logic                  data_out,
  output logic                  write_out,
  output logic                  busy_out,
  output logic                  done_out
);

  localparam int CW = $clog2(DATA_WIDTH + 1);

`ifdef SER_PARITY_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, GAP = 2'd2, PARITY = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, GAP = 2'd2} state_t;
`endif

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] hold_q;
  logic                  hold_full_q;
  logic [DATA_WIDTH-1:0] sh_q, sh_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  load;
  logic                  accept;
  logic                  wr_d, dat_d, done_d;
`ifdef SER_PARITY_EN
  logic                  par_q;
`endif

  // Hold register is empty and we are out of reset; an accept can never coincide with a load.
  assign ready_out = reset & ~hold_full_q;
  assign accept    = valid_in & ready_out;
  assign busy_out  = (state_q != IDLE);

  // Next-state, shifter and registered-output decode; frame starts only from IDLE or GAP.
  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (hold_full_q && !status_in) load = 1'b1;
      end
      SHIFT: begin
        sh_d = {sh_q[DATA_WIDTH-2:0], 1'b0};
        if (cnt_q == '0) begin
          cnt_d = '0;
`ifdef SER_PARITY_EN
          state_d = PARITY;
`else
          state_d = GAP;
`endif
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
`ifdef SER_PARITY_EN
      PARITY: state_d = GAP;
`endif
      GAP: begin
        if (hold_full_q && !status_in) load = 1'b1;
        else                           state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (load) begin
      state_d = SHIFT;
      sh_d    = hold_q;
      cnt_d   = CW'(DATA_WIDTH - 1);
    end

    wr_d   = (state_d == SHIFT);
    dat_d  = (state_d == SHIFT) ? sh_d[DATA_WIDTH-1] : 1'b0;
    done_d = (state_d == GAP);
`ifdef SER_PARITY_EN
    if (state_d == PARITY) begin
      wr_d  = 1'b1;
      dat_d = par_q;
    end
`endif
  end

  // Hold register: filled by the handshake, emptied when its byte moves into the shifter.
  always_ff @(posedge clk_100KHz or negedge reset) begin
    if (!reset) begin
      hold_q      <= '0;
      hold_full_q <= 1'b0;
    end else if (accept) begin
      hold_q      <= data_in;
      hold_full_q <= 1'b1;
    end else if (load) begin
      hold_full_q <= 1'b0;
    end
  end

  // FSM state, shifter, bit counter and glitch-free registered serial outputs.
  always_ff @(posedge clk_100KHz or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      sh_q      <= '0;
      cnt_q     <= '0;
      data_out  <= 1'b0;
      write_out <= 1'b0;
      done_out  <= 1'b0;
    end else begin
      state_q   <= state_d;
      sh_q      <= sh_d;
      cnt_q     <= cnt_d;
      data_out  <= dat_d;
      write_out <= wr_d;
      done_out  <= done_d;
    end
  end

`ifdef SER_PARITY_EN
  // Even parity of the frame byte, captured as it enters the shifter.
  always_ff @(posedge clk_100KHz or negedge reset) begin
    if (!reset)    par_q <= 1'b0;
    else if (load) par_q <= ^hold_q;
  end
`endif

endmodule

// File: tb/tb_serializador.sv
// Randomised and directed bench for serializador with a frame-level scoreboard.
// Latency: checked through accept-to-first-bit and frame spacing measurements.
// Backpressure: status_in is held and randomly toggled; ready_out is observed before each accept.
module tb_serializador;

  localparam int DW = 8;
`ifdef SER_PARITY_EN
  localparam int FB = DW + 1;
`else
  localparam int FB = DW;
`endif

  logic          clk;
  logic          reset;
  logic [DW-1:0] data_in;
  logic          valid_in;
  logic          ready_out;
  logic          status_in;
  logic          data_out;
  logic          write_out;
  logic          busy_out;
  logic          done_out;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit rnd_on = 1'b0;

  int exp_q[$];
  int start_q[$];

  serializador #(.DATA_WIDTH(DW)) dut (
    .clk_100KHz(clk),
    .reset     (reset),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .ready_out (ready_out),
    .status_in (status_in),
    .data_out  (data_out),
    .write_out (write_out),
    .busy_out  (busy_out),
    .done_out  (done_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: a frame is the byte MSB first, optionally followed by the XOR of its bits.
  function automatic int frame_of(input int b);
    int f;
    int ones;
    f = b;
    ones = 0;
    for (int i = 0; i < DW; i++) if (((b >> i) & 1) == 1) ones++;
`ifdef SER_PARITY_EN
    f = (b << 1) | (ones % 2);
`endif
    return f;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_on) status_in = ($urandom_range(0, 3) == 0);
  endtask

  task automatic push(input logic [DW-1:0] b, output int acc_cyc);
    int n;
    n = 0;
    acc_cyc = -1;
    valid_in = 1'b1;
    data_in  = b;
    while (!ready_out && n < 300) begin
      tick();
      n++;
    end
    if (!ready_out) begin
      chk("push_timeout", 0, 1);
      valid_in = 1'b0;
      return;
    end
    @(posedge clk);
    exp_q.push_back(frame_of(int'(b)));
    #1;
    acc_cyc = cyc;
    valid_in = 1'b0;
    if (rnd_on) status_in = ($urandom_range(0, 3) == 0);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(ready_out && !busy_out && exp_q.size() == 0) && n < 400) begin
      tick();
      n++;
    end
    if (n >= 400) chk("idle_timeout", 0, 1);
  endtask

  // Monitor: collects strobed bits, compares each completed frame against the scoreboard.
  int  mon_frame = 0;
  int  mon_bits  = 0;
  bit  prev_w    = 1'b0;
  always @(negedge clk) begin
    if (!reset) begin
      mon_frame = 0;
      mon_bits  = 0;
      prev_w    = 1'b0;
    end else begin
      if (write_out) begin
        if (!prev_w) start_q.push_back(cyc);
        mon_frame = (mon_frame << 1) | int'(data_out);
        mon_bits++;
      end
      prev_w = write_out;
      if (done_out) begin
        chk("gap_write_low", int'(write_out), 0);
        chk("frame_bits", mon_bits, FB);
        if (exp_q.size() == 0) chk("unexpected_frame", mon_frame, -1);
        else chk("frame_data", mon_frame, exp_q.pop_front());
        mon_frame = 0;
        mon_bits  = 0;
      end
    end
  end

  initial begin
    int a1, a2, viol, wcount;
    reset     = 1'b0;
    valid_in  = 1'b0;
    data_in   = '0;
    status_in = 1'b0;
    #2;
    chk("rst_data_out",  int'(data_out),  0);
    chk("rst_write_out", int'(write_out), 0);
    chk("rst_busy_out",  int'(busy_out),  0);
    chk("rst_done_out",  int'(done_out),  0);
    chk("rst_ready_out", int'(ready_out), 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("ready_on_release", int'(ready_out), 1);
    tick();

    // Single byte: ready drops for one cycle, then the frame plays out.
    push(8'hA5, a1);
    chk("a5_ready_low", int'(ready_out), 0);
    tick();
    chk("a5_ready_back", int'(ready_out), 1);
    chk("a5_first_bit_strobe", int'(write_out), 1);
    chk("a5_msb", int'(data_out), 1);
    wait_idle();
    chk("a5_busy_clear", int'(busy_out), 0);

    // Back-to-back: second accept one edge after shift starts, frames spaced by one gap.
    start_q.delete();
    push(8'h3C, a1);
    push(8'hFF, a2);
    chk("b2b_accept_spacing", a2 - a1, 2);
    wait_idle();
    chk("b2b_frames", start_q.size(), 2);
    if (start_q.size() == 2) chk("b2b_frame_period", start_q[1] - start_q[0], FB + 1);

    // Receiver busy: nothing starts until status_in falls.
    status_in = 1'b1;
    push(8'h81, a1);
    viol = 0;
    repeat (20) begin
      tick();
      if (write_out || ready_out) viol++;
    end
    chk("stalled_no_activity", viol, 0);
    status_in = 1'b0;
    tick();
    chk("stall_release_strobe", int'(write_out), 1);
    chk("stall_release_msb", int'(data_out), 1);
    wait_idle();

    // Parity-carrying patterns (plain frames in the default build).
    push(8'h07, a1);
    push(8'hA5, a1);
    wait_idle();

    // Reset mid-frame with a byte pending: frame aborted, pending byte dropped.
    push(8'hF0, a1);
    push(8'h55, a2);
    tick();
    reset = 1'b0;
    exp_q.delete();
    #1;
    chk("abort_write_low", int'(write_out), 0);
    chk("abort_busy_low", int'(busy_out), 0);
    chk("abort_ready_low", int'(ready_out), 0);
    tick();
    reset = 1'b1;
    #1;
    chk("abort_ready_after", int'(ready_out), 1);
    wcount = 0;
    repeat (20) begin
      tick();
      if (write_out) wcount++;
    end
    chk("abort_no_bits", wcount, 0);

    // Random traffic with random receiver back-pressure.
    rnd_on = 1'b1;
    for (int i = 0; i < 40; i++) begin
      push(DW'($urandom_range(0, 255)), a1);
      repeat ($urandom_range(0, 12)) tick();
    end
    rnd_on = 1'b0;
    status_in = 1'b0;
    wait_idle();
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
